input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Front-end stage for the camera/user-control logic. Sits between the board pads and the user-control block.
- Synchronises the four push buttons (btnl, btnr, btnu, btnd) and the 16 slide switches into clk_in, then debounces every channel.
- Drives clean levels to the user-control block, plus single-cycle press pulses and a switch-change pulse for mode/toggle logic.

Parameters:
- DEBOUNCE_CYCLES, 250_000, consecutive cycles a synchronised input must differ from its stable value before the stable value flips (5 ms at 50 MHz). Must be >= 2.
- CNT_WIDTH, $clog2(DEBOUNCE_CYCLES), width of each per-channel counter.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- btnl_in, btnr_in, btnu_in, btnd_in  input  1 each  raw asynchronous button pads
- sw_in  input  16  raw asynchronous switch pads
- btnl_out, btnr_out, btnu_out, btnd_out  output  1 each  debounced button levels
- btnl_press, btnr_press, btnu_press, btnd_press  output  1 each  one-cycle pulse on debounced 0->1
- sw_out  output  16  debounced switch levels
- sw_changed_out  output  1  one-cycle pulse when any sw_out bit changes

Behaviour:
- Clocking and reset: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values: every sync flop, stable value, counter, *_out, *_press and sw_changed_out clear to 0 at the reset edge. Reset overrides everything else, including a count in progress.
- Channels: 20 independent channels (4 buttons + 16 switches), all identical.
- Synchroniser: two-flop chain per channel, sync1 <= pad, then sync2 <= sync1. No logic between the two flops.
- Debounce rule, evaluated per channel on each rising edge:
  - If sync2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - Else: counter <= counter+1.
- Latency: take a pad level that is steady before edge 1, where edge 1 is the first edge that samples it. stable flips at edge DEBOUNCE_CYCLES+2 and is visible in the following cycle.
- Glitches: any return of sync2 to stable before the count completes clears the counter, so the full count restarts.
- Counter range: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Press pulses: btnX_press is registered. It is 1 for exactly the one cycle in which btnX_out first reads 1 after a 0->1 flip, and 0 otherwise. Releases (1->0) produce no pulse.
- sw_changed_out: registered, and 1 for exactly the one cycle in which sw_out first shows a new value. Several bits flipping on the same edge produce a single one-cycle pulse. Flips on consecutive edges produce back-to-back pulses.
- Pads held through reset:
  - After reset deassertion, outputs start at 0.
  - A pad held at 1 flips its stable value at edge DEBOUNCE_CYCLES+2 after deassertion.
  - A held button then emits a press pulse.
  - Held switches then emit sw_changed_out.
- Outputs are direct flop outputs; there is no combinational path from pad to output.

Test Plan:
- DEBOUNCE_CYCLES=8: raise btnu_in before edge 1 and hold it -> btnu_out rises after edge 10, btnu_press is high for exactly that one cycle, and all other outputs stay 0.
- DEBOUNCE_CYCLES=8: btnl_in high for 6 cycles, low for 2, high again and held -> no flip during the glitch; btnl_out rises 10 edges after the final rise; exactly one btnl_press.
- DEBOUNCE_CYCLES=8: sw_in 0x0000 -> 0xA005 in one cycle -> sw_out becomes 0xA005 on a single edge; sw_changed_out is a single one-cycle pulse.
- DEBOUNCE_CYCLES=8: btnd_in held 1 for 50 cycles, then released -> btnd_out falls 10 edges after release; no press pulse on release.
- DEBOUNCE_CYCLES=8: btnr_in high, assert rst_in for 1 cycle at count 5 -> all outputs 0 after the reset edge; btnr_out rises 10 edges after reset deassertion, followed by one btnr_press.
- DEBOUNCE_CYCLES=8: all four buttons pressed on staggered cycles 0..3 -> each output rises independently at edge 10+k, with four separate one-cycle press pulses.

Source files
------------

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Purpose  : Two-flop synchronisers and per-channel debouncers for four push
//            buttons and sixteen slide switches, with press and change pulses.
// Revision : 1.0
// ============================================================================

module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250_000,
   parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        btnl_in,
   input  logic        btnr_in,
   input  logic        btnu_in,
   input  logic        btnd_in,
   input  logic [15:0] sw_in,
   output logic        btnl_out,
   output logic        btnr_out,
   output logic        btnu_out,
   output logic        btnd_out,
   output logic        btnl_press,
   output logic        btnr_press,
   output logic        btnu_press,
   output logic        btnd_press,
   output logic [15:0] sw_out,
   output logic        sw_changed_out
);

   localparam int NUM_BTN = 4;
   localparam int NUM_SW  = 16;
   localparam int NUM_CH  = NUM_BTN + NUM_SW;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   // Channel order: buttons l,r,u,d in bits 0..3, switches in bits 4..19.
   logic [NUM_CH-1:0] pad;
   logic [NUM_CH-1:0] stable_d;
   logic [NUM_CH-1:0] stable_q;

   assign pad = {sw_in, btnd_in, btnu_in, btnr_in, btnl_in};

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
         logic                 sync1_q;
         logic                 sync2_q;
         logic                 st_d;
         logic                 st_q;
         logic [CNT_WIDTH-1:0] cnt_d;
         logic [CNT_WIDTH-1:0] cnt_q;

         always_comb begin
            st_d  = st_q;
            cnt_d = '0;
            if (sync2_q != st_q) begin
               if (cnt_q == CNT_MAX) begin
                  st_d = sync2_q;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end

         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               st_q    <= 1'b0;
               cnt_q   <= '0;
            end else begin
               sync1_q <= pad[i];
               sync2_q <= sync1_q;
               st_q    <= st_d;
               cnt_q   <= cnt_d;
            end
         end

         assign stable_d[i] = st_d;
         assign stable_q[i] = st_q;
      end
   endgenerate

   // Pulses are computed from the next stable value so they line up with the
   // first cycle in which the new level is visible on the outputs.
   logic [NUM_BTN-1:0] press_d;
   logic [NUM_BTN-1:0] press_q;
   logic               sw_changed_d;
   logic               sw_changed_q;

   always_comb begin
      press_d      = stable_d[NUM_BTN-1:0] & ~stable_q[NUM_BTN-1:0];
      sw_changed_d = |(stable_d[NUM_CH-1:NUM_BTN] ^ stable_q[NUM_CH-1:NUM_BTN]);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         press_q      <= '0;
         sw_changed_q <= 1'b0;
      end else begin
         press_q      <= press_d;
         sw_changed_q <= sw_changed_d;
      end
   end

   assign btnl_out       = stable_q[0];
   assign btnr_out       = stable_q[1];
   assign btnu_out       = stable_q[2];
   assign btnd_out       = stable_q[3];
   assign sw_out         = stable_q[NUM_CH-1:NUM_BTN];
   assign btnl_press     = press_q[0];
   assign btnr_press     = press_q[1];
   assign btnu_press     = press_q[2];
   assign btnd_press     = press_q[3];
   assign sw_changed_out = sw_changed_q;

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Purpose  : Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES = 8.
// Revision : 1.0
// ============================================================================

module tb_input_conditioner;

   localparam int D = 8;
   localparam int LAT = D + 2;  // pad set before edge k+1 -> visible after edge k+LAT

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        btnl_in, btnr_in, btnu_in, btnd_in;
   logic [15:0] sw_in;
   logic        btnl_out, btnr_out, btnu_out, btnd_out;
   logic        btnl_press, btnr_press, btnu_press, btnd_press;
   logic [15:0] sw_out;
   logic        sw_changed_out;

   input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .btnl_in(btnl_in), .btnr_in(btnr_in), .btnu_in(btnu_in), .btnd_in(btnd_in),
      .sw_in(sw_in),
      .btnl_out(btnl_out), .btnr_out(btnr_out), .btnu_out(btnu_out), .btnd_out(btnd_out),
      .btnl_press(btnl_press), .btnr_press(btnr_press),
      .btnu_press(btnu_press), .btnd_press(btnd_press),
      .sw_out(sw_out), .sw_changed_out(sw_changed_out)
   );

   always #5 clk_in = ~clk_in;

   // {sw_changed, press d,u,r,l, sw[15:0], btn d,u,r,l}
   logic [24:0] out_vec;
   assign out_vec = {sw_changed_out, btnd_press, btnu_press, btnr_press, btnl_press,
                     sw_out, btnd_out, btnu_out, btnr_out, btnl_out};

   function automatic logic [24:0] mk(input logic [3:0] btn, input logic [3:0] prs,
                                      input logic [15:0] sw, input logic chg);
      return {chg, prs, sw, btn};
   endfunction

   typedef struct {
      int          at_edge;
      logic [24:0] val;
   } ev_t;

   ev_t         sb[$];
   int          edge_cnt = 0;
   int          checks   = 0;
   int          errors   = 0;
   bit          mon_en   = 1'b0;
   logic [24:0] prev     = '0;

   always @(posedge clk_in) edge_cnt++;

   task automatic push(input int at, input logic [24:0] v);
      ev_t e;
      e.at_edge = at;
      e.val     = v;
      sb.push_back(e);
   endtask

   // Monitor: an output change is a DUT response; it must match the next
   // expected snapshot in both value and edge number.
   always @(negedge clk_in) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].at_edge < edge_cnt) begin
            checks++;
            errors++;
            $display("FAIL missing_event: expected %h at edge %0d, not observed (now edge %0d, outputs %h)",
                     sb[0].val, sb[0].at_edge, edge_cnt, out_vec);
            void'(sb.pop_front());
         end
         if (out_vec !== prev) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change: edge %0d outputs %h, previous %h, nothing expected",
                        edge_cnt, out_vec, prev);
            end else begin
               ev_t e;
               e = sb.pop_front();
               if (e.at_edge != edge_cnt || e.val !== out_vec) begin
                  errors++;
                  $display("FAIL event: got %h at edge %0d, required %h at edge %0d",
                           out_vec, edge_cnt, e.val, e.at_edge);
               end
            end
            prev = out_vec;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   int k;

   initial begin
      rst_in = 1'b1;
      btnl_in = 1'b0; btnr_in = 1'b0; btnu_in = 1'b0; btnd_in = 1'b0;
      sw_in = 16'h0000;
      step(3);
      checks++;
      if (out_vec !== 25'h0) begin
         errors++;
         $display("FAIL reset_state: outputs %h, required 0", out_vec);
      end
      rst_in = 1'b0;
      prev   = '0;
      mon_en = 1'b1;
      step(2);

      // Held button: single press pulse aligned with the rising level.
      k = edge_cnt; btnu_in = 1'b1;
      push(k + LAT,     mk(4'b0100, 4'b0100, 16'h0, 1'b0));
      push(k + LAT + 1, mk(4'b0100, 4'b0000, 16'h0, 1'b0));
      step(15);
      k = edge_cnt; btnu_in = 1'b0;
      push(k + LAT, mk(4'b0000, 4'b0000, 16'h0, 1'b0));
      step(15);

      // Glitch: 6 high, 2 low restarts the count; flip 10 edges after final rise.
      btnl_in = 1'b1;
      step(6);
      btnl_in = 1'b0;
      step(2);
      k = edge_cnt; btnl_in = 1'b1;
      push(k + LAT,     mk(4'b0001, 4'b0001, 16'h0, 1'b0));
      push(k + LAT + 1, mk(4'b0001, 4'b0000, 16'h0, 1'b0));
      step(15);
      k = edge_cnt; btnl_in = 1'b0;
      push(k + LAT, mk(4'b0000, 4'b0000, 16'h0, 1'b0));
      step(15);

      // Multi-bit switch change: one edge, one pulse, both directions.
      k = edge_cnt; sw_in = 16'hA005;
      push(k + LAT,     mk(4'b0000, 4'b0000, 16'hA005, 1'b1));
      push(k + LAT + 1, mk(4'b0000, 4'b0000, 16'hA005, 1'b0));
      step(15);
      k = edge_cnt; sw_in = 16'h0000;
      push(k + LAT,     mk(4'b0000, 4'b0000, 16'h0000, 1'b1));
      push(k + LAT + 1, mk(4'b0000, 4'b0000, 16'h0000, 1'b0));
      step(15);

      // Long hold then release: no pulse on the falling edge.
      k = edge_cnt; btnd_in = 1'b1;
      push(k + LAT,     mk(4'b1000, 4'b1000, 16'h0, 1'b0));
      push(k + LAT + 1, mk(4'b1000, 4'b0000, 16'h0, 1'b0));
      step(50);
      k = edge_cnt; btnd_in = 1'b0;
      push(k + LAT, mk(4'b0000, 4'b0000, 16'h0, 1'b0));
      step(15);

      // Reset mid-count (counter at 5) must restart the whole debounce.
      btnr_in = 1'b1;
      step(7);
      rst_in = 1'b1;
      step(1);
      checks++;
      if (out_vec !== 25'h0) begin
         errors++;
         $display("FAIL reset_midcount: outputs %h, required 0", out_vec);
      end
      k = edge_cnt; rst_in = 1'b0;
      push(k + LAT,     mk(4'b0010, 4'b0010, 16'h0, 1'b0));
      push(k + LAT + 1, mk(4'b0010, 4'b0000, 16'h0, 1'b0));
      step(15);
      k = edge_cnt; btnr_in = 1'b0;
      push(k + LAT, mk(4'b0000, 4'b0000, 16'h0, 1'b0));
      step(15);

      // Staggered presses: independent channels, four separate pulses.
      k = edge_cnt;
      btnl_in = 1'b1; step(1);
      btnr_in = 1'b1; step(1);
      btnu_in = 1'b1; step(1);
      btnd_in = 1'b1;
      push(k + LAT,     mk(4'b0001, 4'b0001, 16'h0, 1'b0));
      push(k + LAT + 1, mk(4'b0011, 4'b0010, 16'h0, 1'b0));
      push(k + LAT + 2, mk(4'b0111, 4'b0100, 16'h0, 1'b0));
      push(k + LAT + 3, mk(4'b1111, 4'b1000, 16'h0, 1'b0));
      push(k + LAT + 4, mk(4'b1111, 4'b0000, 16'h0, 1'b0));
      step(15);
      k = edge_cnt;
      btnl_in = 1'b0; btnr_in = 1'b0; btnu_in = 1'b0; btnd_in = 1'b0;
      push(k + LAT, mk(4'b0000, 4'b0000, 16'h0, 1'b0));
      step(15);

      // Switch flips on consecutive edges give back-to-back pulses.
      k = edge_cnt; sw_in = 16'h0001;
      step(1);
      sw_in = 16'h0003;
      push(k + LAT,     mk(4'b0000, 4'b0000, 16'h0001, 1'b1));
      push(k + LAT + 1, mk(4'b0000, 4'b0000, 16'h0003, 1'b1));
      push(k + LAT + 2, mk(4'b0000, 4'b0000, 16'h0003, 1'b0));
      step(15);
      k = edge_cnt; sw_in = 16'h0000;
      push(k + LAT,     mk(4'b0000, 4'b0000, 16'h0000, 1'b1));
      push(k + LAT + 1, mk(4'b0000, 4'b0000, 16'h0000, 1'b0));
      step(15);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected events left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
